ahb_lite_sram_slave: RTL and testbench

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

---
 rtl/ahb_lite_sram_slave_if.sv | 29 ++
 rtl/ahb_lite_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// Clock and reset are kept as plain ports on the modules that use this bundle.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte-lane writes,
// optional wait states and the two-cycle ERROR response for bad transfers.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                  hclk,
  input logic                  hreset,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTE_SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte lanes touched by a transfer, little-endian within the word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    lane_mask = 4'b0001 << off;
      3'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replace only the enabled byte lanes of the stored word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [3:0]            be);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_w[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_w[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Out-of-range, oversize or misaligned transfers get the ERROR response.
  function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size);
    logic err;
    err = 1'b0;
    if ({1'b0, a} >= BYTE_SPAN) err = 1'b1;
    if (size > 3'd2) err = 1'b1;
    if ((size == 3'd1) && a[0]) err = 1'b1;
    if ((size == 3'd2) && (a[1:0] != 2'b00)) err = 1'b1;
    return err;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [3:0]            be_q, be_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic                  accept_s;
  logic                  req_err_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic                  unused_ignored_s;

  assign accept_s         = bus.hsel & bus.hready & bus.htrans[1];
  assign req_err_s        = addr_error(bus.haddr, bus.hsize);
  assign wr_word_s        = merge_lanes(mem[idx_q], bus.hwdata, be_q);
  assign unused_ignored_s = ^{bus.hburst, bus.hprot};

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;

  // Next-state, address-phase capture and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = bus.haddr[IDX_W+1:2];
          write_d = bus.hwrite;
          be_d    = lane_mask(bus.hsize, bus.haddr[1:0]);
          cnt_d   = 3'd0;
          if (req_err_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);

    // A read entering DATA right behind a write to the same word sees the merged data.
    if ((state_d == ST_DATA) && !write_d) begin
      if ((state_q == ST_DATA) && write_q && (idx_q == idx_d)) begin
        hrdata_d = wr_word_s;
      end else begin
        hrdata_d = mem[idx_d];
      end
    end else begin
      hrdata_d = {DATA_WIDTH{1'b0}};
    end
  end

  // Control state and bus outputs; reset discards any in-flight transfer.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= {IDX_W{1'b0}};
      write_q     <= 1'b0;
      be_q        <= 4'b0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      be_q        <= be_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Memory array (not reset): commit the write on the edge that ends its DATA phase.
  always_ff @(posedge hclk) begin
    if ((state_q == ST_DATA) && write_q && !hreset) begin
      mem[idx_q] <= wr_word_s;
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with no wait states,
// one with three, sharing the master-side signals but selected separately.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset0, hreset3;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic        cur_sel;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

  assign if0.hsel   = hsel0;   assign if3.hsel   = hsel3;
  assign if0.haddr  = haddr;   assign if3.haddr  = haddr;
  assign if0.htrans = htrans;  assign if3.htrans = htrans;
  assign if0.hwrite = hwrite;  assign if3.hwrite = hwrite;
  assign if0.hsize  = hsize;   assign if3.hsize  = hsize;
  assign if0.hburst = 3'd0;    assign if3.hburst = 3'd1;
  assign if0.hprot  = 4'd3;    assign if3.hprot  = 4'd3;
  assign if0.hready = hready;  assign if3.hready = hready;
  assign if0.hwdata = hwdata;  assign if3.hwdata = hwdata;

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
    dut0 (.hclk(hclk), .hreset(hreset0), .bus(if0));
  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3))
    dut3 (.hclk(hclk), .hreset(hreset3), .bus(if3));

  wire        cur_ready = cur_sel ? if3.hreadyout : if0.hreadyout;
  wire        cur_resp  = cur_sel ? if3.hresp     : if0.hresp;
  wire [31:0] cur_rdata = cur_sel ? if3.hrdata    : if0.hrdata;

  typedef struct {
    bit          which;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_resp;
    int          exp_waits;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single non-pipelined transfer; reports the completing-cycle response.
  task automatic xfer(input bit which, input logic [31:0] addr, input bit wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp,
                      output int waits, output logic wresp, output logic [31:0] wrdata);
    bit done;
    @(negedge hclk);
    cur_sel = which;
    hsel0 = !which; hsel3 = which;
    htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hready = 1'b1;
    @(posedge hclk); #1;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwdata = wdata;
    waits = 0; done = 1'b0; wresp = 1'b0; wrdata = 32'h0;
    rdata = 32'hx; resp = 1'bx;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge hclk);
      if (cur_ready) begin
        rdata = cur_rdata; resp = cur_resp; done = 1'b1;
      end else begin
        waits++; wresp = wresp | cur_resp; wrdata = wrdata | cur_rdata;
      end
      @(posedge hclk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: got hreadyout=0 for 20 cycles expected completion");
    end
  endtask

  // Address phase that must not be accepted; outputs must stay idle.
  task automatic gap(input bit s, input logic [1:0] tr, input bit rdy, input string name);
    @(negedge hclk);
    cur_sel = 1'b0;
    hsel0 = s; htrans = tr; haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2;
    hready = rdy; hwdata = 32'h0BADF00D;
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00; hready = 1'b1;
    @(negedge hclk);
    check({name, "_hreadyout"}, {31'd0, if0.hreadyout}, 32'd1);
    check({name, "_hresp"},     {31'd0, if0.hresp},     32'd0);
    check({name, "_hrdata"},    if0.hrdata,             32'd0);
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] rd, wrd;
    logic        rs, wrs;
    int          wt;

    vecs[0]  = '{1'b0, 32'h020, 1'b1, 3'd2, 32'h00000000, 32'h0,        1'b0, 0};
    vecs[1]  = '{1'b0, 32'h021, 1'b1, 3'd0, 32'h0000AB00, 32'h0,        1'b0, 0};
    vecs[2]  = '{1'b0, 32'h022, 1'b1, 3'd1, 32'h12340000, 32'h0,        1'b0, 0};
    vecs[3]  = '{1'b0, 32'h020, 1'b0, 3'd2, 32'h0,        32'h1234AB00, 1'b0, 0};
    vecs[4]  = '{1'b0, 32'h023, 1'b0, 3'd0, 32'h0,        32'h1234AB00, 1'b0, 0};
    vecs[5]  = '{1'b0, 32'h000, 1'b1, 3'd2, 32'hA5A5A5A5, 32'h0,        1'b0, 0};
    vecs[6]  = '{1'b0, 32'h400, 1'b1, 3'd2, 32'h11111111, 32'h0,        1'b1, 1};
    vecs[7]  = '{1'b0, 32'h000, 1'b0, 3'd2, 32'h0,        32'hA5A5A5A5, 1'b0, 0};
    vecs[8]  = '{1'b0, 32'h002, 1'b0, 3'd2, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{1'b0, 32'h022, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 32'h011, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
    vecs[11] = '{1'b0, 32'h000, 1'b0, 3'd3, 32'h0,        32'h0,        1'b1, 1};
    vecs[12] = '{1'b0, 32'h020, 1'b0, 3'd2, 32'h0,        32'h1234AB00, 1'b0, 0};
    vecs[13] = '{1'b0, 32'h3FC, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 0};
    vecs[14] = '{1'b0, 32'h3FC, 1'b0, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    vecs[15] = '{1'b0, 32'h3FE, 1'b0, 3'd1, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    vecs[16] = '{1'b0, 32'h3FD, 1'b1, 3'd0, 32'h00007700, 32'h0,        1'b0, 0};
    vecs[17] = '{1'b0, 32'h3FC, 1'b0, 3'd2, 32'h0,        32'hCAFE770D, 1'b0, 0};
    vecs[18] = '{1'b1, 32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 3};
    vecs[19] = '{1'b1, 32'h010, 1'b0, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[20] = '{1'b1, 32'h030, 1'b1, 3'd2, 32'h55AA55AA, 32'h0,        1'b0, 3};
    vecs[21] = '{1'b1, 32'h002, 1'b0, 3'd2, 32'h0,        32'h0,        1'b1, 1};
    vecs[22] = '{1'b1, 32'h030, 1'b0, 3'd2, 32'h0,        32'h55AA55AA, 1'b0, 3};

    hreset0 = 1'b1; hreset3 = 1'b1;
    hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hready = 1'b1; hwdata = 32'h0; cur_sel = 1'b0;

    // Reset state of both instances.
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst0_hreadyout", {31'd0, if0.hreadyout}, 32'd1);
    check("rst0_hresp",     {31'd0, if0.hresp},     32'd0);
    check("rst0_hrdata",    if0.hrdata,             32'd0);
    check("rst3_hreadyout", {31'd0, if3.hreadyout}, 32'd1);
    check("rst3_hresp",     {31'd0, if3.hresp},     32'd0);
    check("rst3_hrdata",    if3.hrdata,             32'd0);

    // Back-to-back word write then read of 0x010, first edge after reset release.
    hreset0 = 1'b0; hreset3 = 1'b0;
    hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge hclk);
    check("b2b_wr_hreadyout", {31'd0, if0.hreadyout}, 32'd1);
    check("b2b_wr_hrdata",    if0.hrdata,             32'd0);
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("b2b_rd_hreadyout", {31'd0, if0.hreadyout}, 32'd1);
    check("b2b_rd_hresp",     {31'd0, if0.hresp},     32'd0);
    check("b2b_rd_hrdata",    if0.hrdata,             32'hDEADBEEF);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("b2b_after_hrdata", if0.hrdata, 32'd0);

    // Table of single transfers.
    for (int i = 0; i < 23; i++) begin
      xfer(vecs[i].which, vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata,
           rd, rs, wt, wrs, wrd);
      check($sformatf("v%0d_hrdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_hresp", i), {31'd0, rs}, {31'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_waits", i), wt, vecs[i].exp_waits);
      check($sformatf("v%0d_wait_hresp", i), {31'd0, wrs},
            {31'd0, (vecs[i].exp_waits > 0) && vecs[i].exp_resp});
      check($sformatf("v%0d_wait_hrdata", i), wrd, 32'd0);
    end

    // Gaps and deselects must neither respond with wait/error nor write.
    gap(1'b1, 2'b00, 1'b1, "gap_idle");
    gap(1'b1, 2'b01, 1'b1, "gap_busy");
    gap(1'b0, 2'b10, 1'b1, "gap_nosel");
    gap(1'b1, 2'b10, 1'b0, "gap_nordy");
    xfer(1'b0, 32'h010, 1'b0, 3'd2, 32'h0, rd, rs, wt, wrs, wrd);
    check("gap_readback_hrdata", rd, 32'hDEADBEEF);
    check("gap_readback_waits",  wt, 32'd0);

    // Reset during the wait states of a write to 0x030.
    @(negedge hclk);
    cur_sel = 1'b1;
    hsel3 = 1'b1; htrans = 2'b10; haddr = 32'h030; hwrite = 1'b1; hsize = 3'd2; hready = 1'b1;
    @(posedge hclk); #1;
    hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'h12121212;
    @(negedge hclk);
    check("rstmid_pre_hreadyout", {31'd0, if3.hreadyout}, 32'd0);
    #1 hreset3 = 1'b1;
    #1;
    check("rstmid_hreadyout", {31'd0, if3.hreadyout}, 32'd1);
    check("rstmid_hresp",     {31'd0, if3.hresp},     32'd0);
    check("rstmid_hrdata",    if3.hrdata,             32'd0);
    @(posedge hclk);
    @(negedge hclk);
    hreset3 = 1'b0;
    xfer(1'b1, 32'h030, 1'b0, 3'd2, 32'h0, rd, rs, wt, wrs, wrd);
    check("rstmid_readback_hrdata", rd, 32'h55AA55AA);
    check("rstmid_readback_hresp",  {31'd0, rs}, 32'd0);
    check("rstmid_readback_waits",  wt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
